mem_lsu: RTL and testbench
==========================

MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Parameter: TIMEOUT_CYC, default 255, number of REQ cycles without dm_ack before abort (1..255).
REQ-002 clk  in  1  single clock; all state updates on the posedge.
REQ-003 rst  in  1  reset, synchronous and active-high; the block is reset on a clk posedge while rst==1.
REQ-004 wd_i / wreg_i / wdata_i  in  5/1/32  destination register, write enable and ALU result from the EX/MEM register.
REQ-005 aluop_i  in  8  operation subtype (`EXE_*_OP).
REQ-006 mem_addr_i  in  32  effective address.
REQ-007 reg2_i  in  32  store data, or the original rt value for lwl/lwr.
REQ-008 flush  in  1  pipeline flush.
REQ-009 dm_ce / dm_we  out  1/1  bus request strobe and write enable.
REQ-010 dm_addr  out  32  word address; bits [1:0] are 0.
REQ-011 dm_sel  out  4  big-endian byte lanes; bit3 = byte at addr offset 0.
REQ-012 dm_data_o  out  32  write data.
REQ-013 dm_data_i / dm_ack  in  32/1  read data and one-cycle acknowledge.
REQ-014 wd_o / wreg_o / wdata_o  out  5/1/32  write-back fields sent to MEM/WB.
REQ-015 stallreq  out  1  stall request to the control module.
REQ-016 bus_err  out  1  one-cycle pulse on timeout abort.

Function
REQ-017 The block SHALL implement an FSM with states IDLE, REQ and DONE.
REQ-018 In IDLE with a non-memory aluop, it SHALL pass wd/wreg/wdata through combinationally, with stallreq=0 and dm_ce=0.
REQ-019 In IDLE with a load/store aluop (and no flush), stallreq SHALL be 1 that cycle; next state is REQ; the address, sel, write data, dest and aluop are latched.
REQ-020 In REQ: dm_ce=1 and stallreq=1; dm_we=1 for stores only; outputs are driven from the latched values.
REQ-021 In REQ, on dm_ack: load data SHALL be captured into a result register and the FSM moves to DONE; the wait counter clears.
REQ-022 In DONE: stallreq=0; wreg_o=latched wreg; wdata_o=captured result; next state is IDLE unconditionally.
REQ-023 Minimum latency is 3 cycles (IDLE, REQ with same-cycle ack, DONE); each extra wait cycle adds 1.
REQ-024 Load extension, by addr[1:0] (big-endian):
- lb/lbu select byte (3-offset)*8 of the word, sign-/zero-extended.
- lh/lhu use offset 0 -> upper half, 2 -> lower half.
- lw uses the full word.
REQ-025 Store lanes: sb sel = 4'b1000>>offset with the byte replicated ×4; sh sel = 1100 or 0011 with the half replicated ×2; sw sel = 1111.
REQ-026 Low address bits that are illegal for lh/lhu/sh/lw/sw SHALL be ignored (truncated); no exception is raised.
REQ-027 The wait counter (8 bit) increments each REQ cycle without ack.
REQ-028 Timeout: when the counter reaches TIMEOUT_CYC, the FSM SHALL go to DONE with wreg_o=0 and pulse bus_err=1 for 1 cycle.
REQ-029 flush=1 in any state SHALL force IDLE next cycle, drop dm_ce, and suppress wreg_o; it takes priority over a simultaneous dm_ack.
REQ-030 dm_ack outside REQ SHALL be ignored.
REQ-031 Stores SHALL set wreg_o=0 unless the incoming wreg_i=1 (passthrough).

Reset
REQ-032 On rst=1: state=IDLE; counter=0; result=0; dm_ce=0; dm_we=0; dm_sel=0; dm_addr=0; dm_data_o=0; wreg_o=0; wd_o=`NOPRegAddr; wdata_o=0; stallreq=0; bus_err=0.
REQ-033 rst asserted mid-transaction SHALL abandon the access immediately; no DONE cycle is produced.

Configuration
REQ-034 Macro LSU_UNALIGNED_EN defined: lwl/lwr SHALL merge the word bytes with reg2_i per MIPS32 big-endian rules, and swl/swr SHALL produce the corresponding partial sel and shifted data.
REQ-035 Macro LSU_UNALIGNED_EN undefined: lwl/lwr/swl/swr SHALL be treated as non-memory operations (no bus access, stallreq=0, wreg_o=0).

Verification
REQ-036 lw at addr 0x100, ack after 2 waits, dm_data_i=0x11223344 -> dm_ce high 3 cycles, stallreq high 4 cycles, DONE wdata_o=0x11223344.
REQ-037 lb at addr 0x103 with data 0x000000F0 -> wdata_o=0xFFFFFFF0; lbu -> 0x000000F0; sel during REQ = 4'b0001.
REQ-038 sh at 0x202, reg2_i=0x0000ABCD -> dm_we=1, dm_sel=0011, dm_data_o=0xABCDABCD, dm_addr=0x200.
REQ-039 Never ack with TIMEOUT_CYC=4 -> 4 REQ cycles, bus_err pulse, wreg_o=0, return to IDLE.
REQ-040 flush coincident with dm_ack -> no write-back; dm_ce=0 and state IDLE next cycle.
REQ-041 lwl at 0x101, data 0xAABBCCDD, reg2_i=0x11223344, macro on -> wdata_o=0xBBCCDD44; macro off -> no bus cycle and wreg_o=0.

Source files
------------

// File: rtl/mem_lsu.sv
// mem_lsu -- MEM-stage load/store unit with a handshake data bus.
//
// One memory access at a time walks IDLE -> REQ -> DONE. While the access is
// in flight the unit raises stallreq. Loads are extended or merged into the
// write-back value when the data arrives. Stores drive byte lanes and
// replicated data onto the bus. A bounded wait counter aborts an access
// that never gets an acknowledge.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   wd_i/wreg_i/wdata_i       write-back fields from EX/MEM
//   aluop_i                   operation subtype (EXE_*_OP encoding)
//   mem_addr_i, reg2_i        effective address; store data or rt for lwl/lwr
//   flush                     pipeline flush, abandons any access
//   dm_ce/dm_we/dm_addr/dm_sel/dm_data_o   bus request side
//   dm_data_i/dm_ack          bus response side (ack is one cycle)
//   wd_o/wreg_o/wdata_o       write-back fields to MEM/WB
//   stallreq                  stall request to the pipeline control
//   bus_err                   one-cycle pulse when an access times out
//
// Configuration macro: LSU_UNALIGNED_EN enables lwl/lwr/swl/swr. Without it
// those four ops do no bus access and never write back.
module mem_lsu #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  input  logic        flush,
  output logic        dm_ce,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_sel,
  output logic [31:0] dm_data_o,
  input  logic [31:0] dm_data_i,
  input  logic        dm_ack,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stallreq,
  output logic        bus_err
);

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LWL_OP = 8'b1110_0010;
  localparam logic [7:0] EXE_LWR_OP = 8'b1110_0110;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;
  localparam logic [7:0] EXE_SWL_OP = 8'b1110_1010;
  localparam logic [7:0] EXE_SWR_OP = 8'b1110_1110;
  localparam logic [4:0] NOP_REG_ADDR = 5'b00000;
  // Last counter value still allowed to wait; the next ack-less cycle aborts.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DONE} state_t;

  function automatic logic is_load(input logic [7:0] op);
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP: is_load = 1'b1;
`ifdef LSU_UNALIGNED_EN
      EXE_LWL_OP, EXE_LWR_OP: is_load = 1'b1;
`endif
      default: is_load = 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [7:0] op);
    case (op)
      EXE_SB_OP, EXE_SH_OP, EXE_SW_OP: is_store = 1'b1;
`ifdef LSU_UNALIGNED_EN
      EXE_SWL_OP, EXE_SWR_OP: is_store = 1'b1;
`endif
      default: is_store = 1'b0;
    endcase
  endfunction

  function automatic logic is_unaligned(input logic [7:0] op);
    is_unaligned = (op == EXE_LWL_OP) || (op == EXE_LWR_OP) ||
                   (op == EXE_SWL_OP) || (op == EXE_SWR_OP);
  endfunction

  // {sel, write data}. Big-endian: sel bit3 is the byte at offset 0.
  // Misaligned low bits of half/word ops are simply dropped.
  function automatic logic [35:0] lanes(input logic [7:0] op, input logic [1:0] off,
                                        input logic [31:0] r);
    case (op)
      EXE_LB_OP, EXE_LBU_OP:  lanes = {4'b1000 >> off, 32'h0};
      EXE_LH_OP, EXE_LHU_OP:  lanes = {(off[1] ? 4'b0011 : 4'b1100), 32'h0};
      EXE_LW_OP:              lanes = {4'b1111, 32'h0};
      EXE_SB_OP:              lanes = {4'b1000 >> off, {4{r[7:0]}}};
      EXE_SH_OP:              lanes = {(off[1] ? 4'b0011 : 4'b1100), {2{r[15:0]}}};
      EXE_SW_OP:              lanes = {4'b1111, r};
`ifdef LSU_UNALIGNED_EN
      EXE_LWL_OP, EXE_LWR_OP: lanes = {4'b1111, 32'h0};
      // ~off == 3 - off for a 2-bit offset
      EXE_SWL_OP:             lanes = {4'b1111 >> off, r >> {off, 3'b000}};
      EXE_SWR_OP:             lanes = {4'b1111 << ~off, r << {~off, 3'b000}};
`endif
      default:                lanes = 36'h0;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [7:0] op, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {~off, 3'b000});
    h = off[1] ? w[15:0] : w[31:16];
    case (op)
      EXE_LB_OP:  load_ext = {{24{b[7]}}, b};
      EXE_LBU_OP: load_ext = {24'h0, b};
      EXE_LH_OP:  load_ext = {{16{h[15]}}, h};
      EXE_LHU_OP: load_ext = {16'h0, h};
      default:    load_ext = w;
    endcase
  endfunction

`ifdef LSU_UNALIGNED_EN
  // lwl keeps the low bytes of rt below the loaded bytes; lwr keeps the high ones.
  function automatic logic [31:0] load_merge(input logic [7:0] op, input logic [1:0] off,
                                             input logic [31:0] w, input logic [31:0] r);
    if (op == EXE_LWL_OP) begin
      case (off)
        2'd0:    load_merge = w;
        2'd1:    load_merge = {w[23:0], r[7:0]};
        2'd2:    load_merge = {w[15:0], r[15:0]};
        default: load_merge = {w[7:0], r[23:0]};
      endcase
    end else if (op == EXE_LWR_OP) begin
      case (off)
        2'd0:    load_merge = {r[31:8], w[31:24]};
        2'd1:    load_merge = {r[31:16], w[31:16]};
        2'd2:    load_merge = {r[31:24], w[31:8]};
        default: load_merge = w;
      endcase
    end else begin
      load_merge = load_ext(op, off, w);
    end
  endfunction
`endif

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] result_q, result_d;
  logic        timeout_q, timeout_d;
  logic [31:2] addr_q, addr_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] sdata_q, sdata_d;
  logic [4:0]  wd_q, wd_d;
  logic        wreg_q, wreg_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  aluop_q, aluop_d;
  logic [1:0]  off_q, off_d;
`ifdef LSU_UNALIGNED_EN
  logic [31:0] reg2_q, reg2_d;
`endif
  logic [35:0] lanes_in;
  logic [31:0] ld_word;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    timeout_d = 1'b0;
    addr_d    = addr_q;
    sel_d     = sel_q;
    sdata_d   = sdata_q;
    wd_d      = wd_q;
    wreg_d    = wreg_q;
    wdata_d   = wdata_q;
    aluop_d   = aluop_q;
    off_d     = off_q;
`ifdef LSU_UNALIGNED_EN
    reg2_d    = reg2_q;
    ld_word   = load_merge(aluop_q, off_q, dm_data_i, reg2_q);
`else
    ld_word   = load_ext(aluop_q, off_q, dm_data_i);
`endif
    lanes_in  = lanes(aluop_i, mem_addr_i[1:0], reg2_i);
    case (state_q)
      ST_IDLE: begin
        cnt_d = 8'd0;
        if (!flush && (is_load(aluop_i) || is_store(aluop_i))) begin
          state_d          = ST_REQ;
          addr_d           = mem_addr_i[31:2];
          {sel_d, sdata_d} = lanes_in;
          wd_d             = wd_i;
          wreg_d           = wreg_i;
          wdata_d          = wdata_i;
          aluop_d          = aluop_i;
          off_d            = mem_addr_i[1:0];
`ifdef LSU_UNALIGNED_EN
          reg2_d           = reg2_i;
`endif
        end
      end
      ST_REQ: begin
        // Flush beats ack; ack beats the timeout on the same cycle.
        if (flush) begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end else if (dm_ack) begin
          state_d  = ST_DONE;
          cnt_d    = 8'd0;
          result_d = is_load(aluop_q) ? ld_word : wdata_q;
        end else if (cnt_q == TO_LAST) begin
          state_d   = ST_DONE;
          cnt_d     = 8'd0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd0;
      result_q  <= 32'h0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      timeout_q <= timeout_d;
    end
    addr_q  <= addr_d;
    sel_q   <= sel_d;
    sdata_q <= sdata_d;
    wd_q    <= wd_d;
    wreg_q  <= wreg_d;
    wdata_q <= wdata_d;
    aluop_q <= aluop_d;
    off_q   <= off_d;
`ifdef LSU_UNALIGNED_EN
    reg2_q  <= reg2_d;
`endif
  end

  // Outputs follow the current state; rst forces the idle bus and a NOP write-back.
  always_comb begin
    dm_ce     = 1'b0;
    dm_we     = 1'b0;
    dm_addr   = 32'h0;
    dm_sel    = 4'h0;
    dm_data_o = 32'h0;
    wd_o      = NOP_REG_ADDR;
    wreg_o    = 1'b0;
    wdata_o   = 32'h0;
    stallreq  = 1'b0;
    bus_err   = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_IDLE: begin
          wd_o    = wd_i;
          wdata_o = wdata_i;
          if (is_load(aluop_i) || is_store(aluop_i)) stallreq = ~flush;
          else if (is_unaligned(aluop_i))           wreg_o   = 1'b0;
          else                                      wreg_o   = wreg_i & ~flush;
        end
        ST_REQ: begin
          dm_ce     = ~flush;
          dm_we     = is_store(aluop_q) & ~flush;
          dm_addr   = {addr_q, 2'b00};
          dm_sel    = sel_q;
          dm_data_o = sdata_q;
          stallreq  = ~flush;
          wd_o      = wd_q;
        end
        ST_DONE: begin
          wd_o    = wd_q;
          wreg_o  = wreg_q & ~timeout_q & ~flush;
          wdata_o = result_q;
          bus_err = timeout_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
module tb_mem_lsu;

  localparam int TO = 4;

  localparam logic [7:0] OP_LB  = 8'b1110_0000;
  localparam logic [7:0] OP_LBU = 8'b1110_0100;
  localparam logic [7:0] OP_LH  = 8'b1110_0001;
  localparam logic [7:0] OP_LHU = 8'b1110_0101;
  localparam logic [7:0] OP_LW  = 8'b1110_0011;
  localparam logic [7:0] OP_LWL = 8'b1110_0010;
  localparam logic [7:0] OP_LWR = 8'b1110_0110;
  localparam logic [7:0] OP_SB  = 8'b1110_1000;
  localparam logic [7:0] OP_SH  = 8'b1110_1001;
  localparam logic [7:0] OP_SW  = 8'b1110_1011;
  localparam logic [7:0] OP_SWL = 8'b1110_1010;
  localparam logic [7:0] OP_SWR = 8'b1110_1110;
  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_ADD = 8'h20;

  logic        clk, rst;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic [7:0]  aluop_i;
  logic [31:0] mem_addr_i, reg2_i;
  logic        flush;
  logic        dm_ce, dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_sel;
  logic [31:0] dm_data_o, dm_data_i;
  logic        dm_ack;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stallreq, bus_err;

  int total = 0;
  int bad   = 0;

  mem_lsu #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i), .flush(flush),
    .dm_ce(dm_ce), .dm_we(dm_we), .dm_addr(dm_addr), .dm_sel(dm_sel),
    .dm_data_o(dm_data_o), .dm_data_i(dm_data_i), .dm_ack(dm_ack),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .stallreq(stallreq),
    .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not end in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr, reg2, data;
    int          waits;
    logic        wreg;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic [31:0] dout, res;
    logic        we, ewreg;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] op, input logic [31:0] addr, reg2, data,
                              input int waits, input logic wreg, input logic [31:0] wdata,
                              input logic [3:0] sel, input logic [31:0] dout, res,
                              input logic we, ewreg);
    vec_t v;
    v.op = op; v.addr = addr; v.reg2 = reg2; v.data = data; v.waits = waits;
    v.wreg = wreg; v.wdata = wdata; v.sel = sel; v.dout = dout; v.res = res;
    v.we = we; v.ewreg = ewreg;
    return v;
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model (from the architectural rules) ----------
  function automatic bit m_is_load(input logic [7:0] op);
    bit r;
    r = (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) || (op == OP_LHU) || (op == OP_LW);
`ifdef LSU_UNALIGNED_EN
    r = r || (op == OP_LWL) || (op == OP_LWR);
`endif
    return r;
  endfunction

  function automatic bit m_is_store(input logic [7:0] op);
    bit r;
    r = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
`ifdef LSU_UNALIGNED_EN
    r = r || (op == OP_SWL) || (op == OP_SWR);
`endif
    return r;
  endfunction

  function automatic bit m_unal(input logic [7:0] op);
    return (op == OP_LWL) || (op == OP_LWR) || (op == OP_SWL) || (op == OP_SWR);
  endfunction

  function automatic logic [3:0] m_sel(input logic [7:0] op, input logic [31:0] addr);
    int off;
    off = int'(addr[1:0]);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 4'b1000 >> off;
      OP_LH, OP_LHU, OP_SH: return (off < 2) ? 4'b1100 : 4'b0011;
      OP_LW, OP_SW:         return 4'b1111;
      OP_SWL:               return 4'b1111 >> off;
      OP_SWR:               return 4'b1111 << (3 - off);
      default:              return 4'bxxxx;
    endcase
  endfunction

  function automatic logic [31:0] m_dout(input logic [7:0] op, input logic [31:0] addr,
                                         input logic [31:0] r);
    int off;
    off = int'(addr[1:0]);
    case (op)
      OP_SB:   return (r & 32'hFF) * 32'h0101_0101;
      OP_SH:   return (r & 32'hFFFF) * 32'h0001_0001;
      OP_SW:   return r;
      OP_SWL:  return r >> (8 * off);
      OP_SWR:  return r << (8 * (3 - off));
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [7:0] op, input logic [31:0] addr,
                                         input logic [31:0] w, input logic [31:0] r);
    int off, sh;
    logic [31:0] b, h;
    off = int'(addr[1:0]);
    b = (w >> (8 * (3 - off))) & 32'hFF;
    h = (off < 2) ? (w >> 16) : (w & 32'hFFFF);
    sh = 8 * (3 - off);
    case (op)
      OP_LB:   return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
      OP_LBU:  return b;
      OP_LH:   return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      OP_LHU:  return h;
      OP_LWL:  return (w << (8 * off)) | (r & ((32'h1 << (8 * off)) - 32'h1));
      OP_LWR:  return (w >> sh) | (r & ~(32'hFFFF_FFFF >> sh));
      default: return w;
    endcase
  endfunction

  // ---------------- drivers -------------------------------------------------
  task automatic txn(input vec_t v);
    logic [4:0] wd;
    bit tmo;
    int last;
    wd = 5'($urandom_range(1, 31));
    tmo = (v.waits >= TO);
    last = tmo ? TO - 1 : v.waits;
    aluop_i = v.op; mem_addr_i = v.addr; reg2_i = v.reg2; wd_i = wd;
    wreg_i = v.wreg; wdata_i = v.wdata; flush = 1'b0;
    dm_ack = 1'($urandom_range(0, 1)); dm_data_i = $urandom;
    #3;
    chk1("idle_stall", stallreq, 1'b1);
    chk1("idle_ce", dm_ce, 1'b0);
    chk1("idle_buserr", bus_err, 1'b0);
    step();
    for (int k = 0; k <= last; k++) begin
      dm_ack = (k == v.waits);
      dm_data_i = dm_ack ? v.data : $urandom;
      #3;
      chk1("req_ce", dm_ce, 1'b1);
      chk1("req_we", dm_we, v.we);
      chk1("req_stall", stallreq, 1'b1);
      chk1("req_buserr", bus_err, 1'b0);
      chk32("req_addr", dm_addr, {v.addr[31:2], 2'b00});
      if (!$isunknown(v.sel)) chk32("req_sel", 32'(dm_sel), 32'(v.sel));
      if (v.we) chk32("req_dout", dm_data_o, v.dout);
      step();
    end
    dm_ack = 1'($urandom_range(0, 1)); dm_data_i = $urandom;
    aluop_i = OP_NOP; wreg_i = 1'b0;
    #3;
    chk1("done_stall", stallreq, 1'b0);
    chk1("done_ce", dm_ce, 1'b0);
    chk1("done_buserr", bus_err, tmo);
    chk1("done_wreg", wreg_o, v.ewreg & ~tmo);
    chk32("done_wd", 32'(wd_o), 32'(wd));
    if (v.ewreg && !tmo) chk32("done_wdata", wdata_o, v.res);
    step();
  endtask

  task automatic pass(input logic [7:0] op, input logic wreg, input logic [31:0] wdata,
                      input logic exp_wreg);
    logic [4:0] wd;
    wd = 5'($urandom_range(0, 31));
    aluop_i = op; wd_i = wd; wreg_i = wreg; wdata_i = wdata; flush = 1'b0;
    mem_addr_i = $urandom; reg2_i = $urandom;
    dm_ack = 1'($urandom_range(0, 1)); dm_data_i = $urandom;
    #3;
    chk1("pass_wreg", wreg_o, exp_wreg);
    chk32("pass_wdata", wdata_o, wdata);
    chk32("pass_wd", 32'(wd_o), 32'(wd));
    chk1("pass_stall", stallreq, 1'b0);
    chk1("pass_ce", dm_ce, 1'b0);
    step();
  endtask

  vec_t tbl[$];

  initial begin
    logic [7:0] ops [0:13];
    ops = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR,
            OP_SB, OP_SH, OP_SW, OP_SWL, OP_SWR, OP_NOP, OP_ADD};

    // reset: outputs forced quiet even with a live load on the inputs
    rst = 1'b1; flush = 1'b0; aluop_i = OP_LW; wd_i = 5'd7; wreg_i = 1'b1;
    wdata_i = 32'h1234; mem_addr_i = 32'h100; reg2_i = 32'h0;
    dm_ack = 1'b1; dm_data_i = 32'hFFFF_FFFF;
    step(); step();
    #3;
    chk1("rst_ce", dm_ce, 1'b0);
    chk1("rst_we", dm_we, 1'b0);
    chk1("rst_wreg", wreg_o, 1'b0);
    chk32("rst_wd", 32'(wd_o), 32'h0);
    chk32("rst_wdata", wdata_o, 32'h0);
    chk1("rst_stall", stallreq, 1'b0);
    chk1("rst_buserr", bus_err, 1'b0);
    chk32("rst_addr", dm_addr, 32'h0);
    chk32("rst_sel", 32'(dm_sel), 32'h0);
    chk32("rst_dout", dm_data_o, 32'h0);
    aluop_i = OP_NOP; dm_ack = 1'b0;
    step();
    rst = 1'b0;
    step();

    // directed vectors
    tbl.push_back(mk(OP_LW,  32'h100, 32'h0, 32'h1122_3344, 2, 1'b1, 32'h0, 4'b1111, 32'h0, 32'h1122_3344, 1'b0, 1'b1));
    tbl.push_back(mk(OP_LB,  32'h103, 32'h0, 32'h0000_00F0, 0, 1'b1, 32'h0, 4'b0001, 32'h0, 32'hFFFF_FFF0, 1'b0, 1'b1));
    tbl.push_back(mk(OP_LBU, 32'h103, 32'h0, 32'h0000_00F0, 1, 1'b1, 32'h0, 4'b0001, 32'h0, 32'h0000_00F0, 1'b0, 1'b1));
    tbl.push_back(mk(OP_LH,  32'h101, 32'h0, 32'h8765_1234, 0, 1'b1, 32'h0, 4'b1100, 32'h0, 32'hFFFF_8765, 1'b0, 1'b1));
    tbl.push_back(mk(OP_LHU, 32'h102, 32'h0, 32'h8765_1234, 3, 1'b1, 32'h0, 4'b0011, 32'h0, 32'h0000_1234, 1'b0, 1'b1));
    tbl.push_back(mk(OP_SH,  32'h202, 32'h0000_ABCD, 32'h0, 1, 1'b0, 32'h55, 4'b0011, 32'hABCD_ABCD, 32'h55, 1'b1, 1'b0));
    tbl.push_back(mk(OP_SB,  32'h101, 32'h1234_565A, 32'h0, 0, 1'b1, 32'h66, 4'b0100, 32'h5A5A_5A5A, 32'h66, 1'b1, 1'b1));
    tbl.push_back(mk(OP_SW,  32'h303, 32'hDEAD_BEEF, 32'h0, 2, 1'b0, 32'h77, 4'b1111, 32'hDEAD_BEEF, 32'h77, 1'b1, 1'b0));
    tbl.push_back(mk(OP_LW,  32'h104, 32'h0, 32'h0, 99, 1'b1, 32'h0, 4'b1111, 32'h0, 32'h0, 1'b0, 1'b1));
`ifdef LSU_UNALIGNED_EN
    tbl.push_back(mk(OP_LWL, 32'h101, 32'h1122_3344, 32'hAABB_CCDD, 0, 1'b1, 32'h0, 4'bxxxx, 32'h0, 32'hBBCC_DD44, 1'b0, 1'b1));
`endif
    foreach (tbl[i]) txn(tbl[i]);

`ifndef LSU_UNALIGNED_EN
    pass(OP_LWL, 1'b1, 32'h0BAD_0001, 1'b0);
    pass(OP_SWR, 1'b1, 32'h0BAD_0002, 1'b0);
`endif
    pass(OP_ADD, 1'b1, 32'h1357_9BDF, 1'b1);

    // flush together with ack: no write-back, back in IDLE
    aluop_i = OP_LW; mem_addr_i = 32'h100; wreg_i = 1'b1; wd_i = 5'd3; flush = 1'b0;
    step();
    dm_ack = 1'b1; flush = 1'b1; dm_data_i = 32'h5555_5555;
    #3;
    chk1("flush_ce", dm_ce, 1'b0);
    chk1("flush_wreg", wreg_o, 1'b0);
    step();
    dm_ack = 1'b0; flush = 1'b0; aluop_i = OP_NOP; wreg_i = 1'b1; wdata_i = 32'hA5A5_0001;
    #3;
    chk1("postflush_ce", dm_ce, 1'b0);
    chk1("postflush_stall", stallreq, 1'b0);
    chk1("postflush_wreg", wreg_o, 1'b1);
    chk32("postflush_wdata", wdata_o, 32'hA5A5_0001);
    step();

    // flush on the IDLE cycle of a load: no stall, no access starts
    aluop_i = OP_LW; flush = 1'b1; wreg_i = 1'b1;
    #3;
    chk1("idleflush_stall", stallreq, 1'b0);
    chk1("idleflush_wreg", wreg_o, 1'b0);
    step();
    flush = 1'b0; aluop_i = OP_NOP; wdata_i = 32'h0000_0F0F;
    #3;
    chk1("idleflush_ce", dm_ce, 1'b0);
    chk32("idleflush_wdata", wdata_o, 32'h0000_0F0F);
    step();

    // reset in the middle of an access: no DONE cycle follows
    aluop_i = OP_LW; mem_addr_i = 32'h200;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; aluop_i = OP_NOP; wreg_i = 1'b1; wdata_i = 32'h0BAD_0003;
    #3;
    chk1("midrst_stall", stallreq, 1'b0);
    chk1("midrst_ce", dm_ce, 1'b0);
    chk1("midrst_wreg", wreg_o, 1'b1);
    chk32("midrst_wdata", wdata_o, 32'h0BAD_0003);
    step();

    // randomized traffic against the model
    for (int n = 0; n < 60; n++) begin
      logic [7:0]  op;
      logic [31:0] addr, r2, d, wdt;
      logic        wr;
      vec_t v;
      op = ops[$urandom_range(0, 13)];
      addr = $urandom; r2 = $urandom; d = $urandom; wdt = $urandom;
      wr = 1'($urandom_range(0, 1));
      if (m_is_load(op) || m_is_store(op)) begin
        v = mk(op, addr, r2, d, $urandom_range(0, 5), wr, wdt, m_sel(op, addr),
               m_dout(op, addr, r2), m_is_load(op) ? m_load(op, addr, d, r2) : wdt,
               m_is_store(op), wr);
        txn(v);
      end else begin
        pass(op, wr, wdt, m_unal(op) ? 1'b0 : wr);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
